// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Shares one common data bus among NREQ result producers (ALU, load/store
// buffer, branch unit). Each producer owns a small FIFO of {rob tag, result}
// entries; a round-robin arbiter pops at most one head per cycle and drives
// a registered broadcast. A flush discards everything buffered.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset (wins over rdy and flush)
//   rdy          global enable; when low every piece of state holds
//   flush        misprediction recovery; drops buffered and in-flight results
//   req_valid    per-producer result valid
//   req_result   per-producer result, producer i at [i*DW +: DW]
//   req_rob      per-producer ROB tag, producer i at [i*ROBW +: ROBW]
//   req_ready    per-producer FIFO has room (from registered count only)
//   cdb_sgn      broadcast valid
//   cdb_result   broadcast value
//   cdb_rob_name broadcast ROB tag
//   cdb_src      index of the producer that was granted
//
// cdb_src is 2 bits wide, so NREQ must not exceed 4.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NREQ  = 3,
  parameter int DEPTH = 2,
  parameter int ROBW  = 4,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_result,
  input  logic [NREQ*ROBW-1:0] req_rob,
  output logic [NREQ-1:0]      req_ready,
  output logic                 cdb_sgn,
  output logic [DW-1:0]        cdb_result,
  output logic [ROBW-1:0]      cdb_rob_name,
  output logic [1:0]           cdb_src
);

  localparam int EW = ROBW + DW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic              advance;
  logic [NREQ-1:0]   nonempty;
  logic [NREQ-1:0]   push;
  logic [NREQ-1:0]   pop;
  logic [NREQ*EW-1:0] head_flat;
  logic [EW-1:0]     grant_head;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        rr_next;
  logic [1:0]        rr_ptr_reg;
  int                arb_idx;

  // Nothing moves unless the pipeline is enabled and not being flushed.
  assign advance = rdy & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_fifo
      logic [EW-1:0] mem [DEPTH];
      logic [PW-1:0] wptr_reg;
      logic [PW-1:0] rptr_reg;
      logic [CW-1:0] count_reg;

      // Ready looks only at the registered count: a full FIFO refuses a push
      // even in the cycle its head is being popped.
      assign req_ready[gi] = (count_reg < FULL);
      assign nonempty[gi]  = (count_reg != '0);
      assign push[gi]      = advance & req_valid[gi] & req_ready[gi];
      assign pop[gi]       = advance & grant_valid & (grant_idx == 2'(gi));
      assign head_flat[gi*EW +: EW] = mem[rptr_reg];

      always_ff @(posedge clk) begin
        if (rst) begin
          wptr_reg  <= '0;
          rptr_reg  <= '0;
          count_reg <= '0;
        end else if (rdy) begin
          if (flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
          end else begin
            if (push[gi]) wptr_reg <= wptr_reg + PW'(1);
            if (pop[gi])  rptr_reg <= rptr_reg + PW'(1);
            case ({push[gi], pop[gi]})
              2'b10:   count_reg <= count_reg + CW'(1);
              2'b01:   count_reg <= count_reg - CW'(1);
              default: count_reg <= count_reg;
            endcase
          end
        end
      end

      // Storage needs no reset: count_reg alone decides which slots are live.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wptr_reg] <= {req_rob[gi*ROBW +: ROBW], req_result[gi*DW +: DW]};
        end
      end
    end
  endgenerate

  // Round-robin search starting at rr_ptr; first non-empty FIFO wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    arb_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!grant_valid && nonempty[arb_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(arb_idx);
      end
    end
  end

  assign rr_next    = (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
  assign grant_head = head_flat[int'(grant_idx)*EW +: EW];

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_sgn      <= 1'b0;
      cdb_result   <= '0;
      cdb_rob_name <= '0;
      cdb_src      <= '0;
      rr_ptr_reg   <= '0;
    end else if (rdy) begin
      if (flush) begin
        // A grant computed in the flush cycle is squashed; payload fields hold.
        cdb_sgn    <= 1'b0;
        rr_ptr_reg <= '0;
      end else if (grant_valid) begin
        cdb_sgn      <= 1'b1;
        cdb_result   <= grant_head[DW-1:0];
        cdb_rob_name <= grant_head[EW-1:DW];
        cdb_src      <= grant_idx;
        rr_ptr_reg   <= rr_next;
      end else begin
        cdb_sgn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed stimulus for cdb_arbiter with a queue-based reference model that
// is compared against the DUT outputs on every falling edge, plus literal
// expectations worked out by hand for each scenario.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
  localparam int NREQ  = 3;
  localparam int DEPTH = 2;
  localparam int ROBW  = 4;
  localparam int DW    = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rdy = 1'b0;
  logic                 flush = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_result = '0;
  logic [NREQ*ROBW-1:0] req_rob = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 cdb_sgn;
  logic [DW-1:0]        cdb_result;
  logic [ROBW-1:0]      cdb_rob_name;
  logic [1:0]           cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .ROBW(ROBW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_result   (req_result),
    .req_rob      (req_rob),
    .req_ready    (req_ready),
    .cdb_sgn      (cdb_sgn),
    .cdb_result   (cdb_result),
    .cdb_rob_name (cdb_rob_name),
    .cdb_src      (cdb_src)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [ROBW+DW-1:0] mq [NREQ][$];
  logic               m_sgn;
  logic [DW-1:0]      m_res;
  logic [ROBW-1:0]    m_rob;
  logic [1:0]         m_src;
  int                 m_rr;
  int                 m_sz [NREQ];
  int                 m_g;
  logic [ROBW+DW-1:0] m_e;
  logic [NREQ-1:0]    m_ready;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_sgn = 1'b0; m_res = '0; m_rob = '0; m_src = '0; m_rr = 0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        m_sgn = 1'b0;
        m_rr  = 0;
      end else begin
        for (int i = 0; i < NREQ; i++) m_sz[i] = mq[i].size();
        m_g = -1;
        for (int k = 0; k < NREQ; k++)
          if (m_g < 0 && m_sz[(m_rr + k) % NREQ] > 0) m_g = (m_rr + k) % NREQ;
        if (m_g >= 0) begin
          m_e   = mq[m_g].pop_front();
          m_sgn = 1'b1;
          m_res = m_e[DW-1:0];
          m_rob = m_e[DW +: ROBW];
          m_src = 2'(m_g);
          m_rr  = (m_g + 1) % NREQ;
        end else begin
          m_sgn = 1'b0;
        end
        for (int i = 0; i < NREQ; i++)
          if (req_valid[i] && m_sz[i] < DEPTH)
            mq[i].push_back({req_rob[i*ROBW +: ROBW], req_result[i*DW +: DW]});
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < NREQ; i++) m_ready[i] = (mq[i].size() < DEPTH);
      chk("cmp_sgn", 32'(cdb_sgn), 32'(m_sgn));
      chk("cmp_result", cdb_result, m_res);
      chk("cmp_rob", 32'(cdb_rob_name), 32'(m_rob));
      chk("cmp_src", 32'(cdb_src), 32'(m_src));
      chk("cmp_ready", 32'(req_ready), 32'(m_ready));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] r, input logic [ROBW-1:0] t);
    req_valid[i] = v;
    req_result[i*DW +: DW] = r;
    req_rob[i*ROBW +: ROBW] = t;
  endtask

  task automatic idle();
    req_valid = '0;
    flush = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  int tag [NREQ];
  int exp_tag [NREQ];
  logic [NREQ-1:0] acc;
  int nb;
  int cyc;

  initial begin
    rdy = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    // reset state
    chk("rst_sgn", 32'(cdb_sgn), 32'd0);
    chk("rst_result", cdb_result, 32'd0);
    chk("rst_rob", 32'(cdb_rob_name), 32'd0);
    chk("rst_src", 32'(cdb_src), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'b111);

    // 1: single ALU push, two-edge latency
    set_req(0, 1'b1, 32'h0000_00AA, 4'd5);
    tick();
    idle();
    tick();
    chk("t1_sgn", 32'(cdb_sgn), 32'd1);
    chk("t1_rob", 32'(cdb_rob_name), 32'd5);
    chk("t1_result", cdb_result, 32'h0000_00AA);
    chk("t1_src", 32'(cdb_src), 32'd0);
    tick();
    chk("t1_sgn_drop", 32'(cdb_sgn), 32'd0);

    // 2: all producers stream tags 1..6
    do_reset();
    for (int i = 0; i < NREQ; i++) begin tag[i] = 1; exp_tag[i] = 1; end
    nb = 0;
    cyc = 0;
    while (nb < 18 && cyc < 80) begin
      for (int i = 0; i < NREQ; i++) begin
        if (tag[i] <= 6) set_req(i, 1'b1, 32'(i*256 + tag[i]), 4'(tag[i]));
        else req_valid[i] = 1'b0;
        acc[i] = req_valid[i] && (mq[i].size() < DEPTH);
      end
      tick();
      cyc++;
      for (int i = 0; i < NREQ; i++) if (acc[i]) tag[i]++;
      if (cyc == 2) chk("t2_ready_edge2", 32'(req_ready), 32'b001);
      if (cdb_sgn) begin
        if (nb < 6) chk("t2_src_seq", 32'(cdb_src), 32'(nb % 3));
        if (cdb_src < 2'd3) begin
          chk("t2_tag_order", 32'(cdb_rob_name), 32'(exp_tag[cdb_src]));
          chk("t2_result", cdb_result, 32'(int'(cdb_src)*256 + exp_tag[cdb_src]));
          exp_tag[cdb_src]++;
        end
        nb++;
      end
    end
    chk("t2_broadcast_count", 32'(nb), 32'd18);
    idle();

    // 3: FIFO 1 full, same-cycle pop does not re-enable the push
    do_reset();
    set_req(0, 1'b1, 32'h30, 4'd1);
    set_req(1, 1'b1, 32'h31, 4'd8);
    set_req(2, 1'b1, 32'h32, 4'd2);
    tick();
    req_valid = 3'b010;
    set_req(1, 1'b1, 32'h39, 4'd9);
    tick();
    chk("t3_ready1_full", 32'(req_ready[1]), 32'd0);
    chk("t3_src_e2", 32'(cdb_src), 32'd0);
    set_req(1, 1'b1, 32'h3A, 4'd10);
    tick();
    chk("t3_ready1_back", 32'(req_ready[1]), 32'd1);
    chk("t3_src_e3", 32'(cdb_src), 32'd1);
    chk("t3_rob_e3", 32'(cdb_rob_name), 32'd8);
    tick();
    idle();
    chk("t3_src_e4", 32'(cdb_src), 32'd2);
    tick();
    chk("t3_rob_e5", 32'(cdb_rob_name), 32'd9);
    tick();
    chk("t3_rob_e6", 32'(cdb_rob_name), 32'd10);
    chk("t3_res_e6", cdb_result, 32'h3A);
    tick();
    chk("t3_sgn_e7", 32'(cdb_sgn), 32'd0);

    // 4: flush with two buffered and a simultaneous push
    do_reset();
    set_req(0, 1'b1, 32'h40, 4'd1);
    tick();
    req_valid = '0;
    set_req(1, 1'b1, 32'h41, 4'd2);
    set_req(2, 1'b1, 32'h42, 4'd3);
    tick();
    chk("t4_pre_rob", 32'(cdb_rob_name), 32'd1);
    req_valid = '0;
    set_req(2, 1'b1, 32'h43, 4'd4);
    flush = 1'b1;
    tick();
    chk("t4_flush_sgn", 32'(cdb_sgn), 32'd0);
    chk("t4_flush_ready", 32'(req_ready), 32'b111);
    idle();
    tick();
    chk("t4_empty_sgn", 32'(cdb_sgn), 32'd0);
    set_req(0, 1'b1, 32'h44, 4'd5);
    set_req(2, 1'b1, 32'h45, 4'd6);
    tick();
    idle();
    tick();
    chk("t4_rr0_src", 32'(cdb_src), 32'd0);
    chk("t4_rr0_rob", 32'(cdb_rob_name), 32'd5);
    tick();
    chk("t4_next_rob", 32'(cdb_rob_name), 32'd6);
    tick();
    chk("t4_drained", 32'(cdb_sgn), 32'd0);

    // 5: rdy low freezes everything, including a flush
    do_reset();
    set_req(0, 1'b1, 32'h77, 4'd7);
    set_req(1, 1'b1, 32'h7B, 4'd11);
    set_req(2, 1'b1, 32'h7C, 4'd12);
    tick();
    idle();
    tick();
    chk("t5_rob7", 32'(cdb_rob_name), 32'd7);
    for (int h = 0; h < 3; h++) begin
      rdy = 1'b0;
      flush = (h == 1);
      tick();
      chk("t5_hold_sgn", 32'(cdb_sgn), 32'd1);
      chk("t5_hold_rob", 32'(cdb_rob_name), 32'd7);
      chk("t5_hold_res", cdb_result, 32'h77);
    end
    idle();
    tick();
    chk("t5_resume_src", 32'(cdb_src), 32'd1);
    chk("t5_resume_rob", 32'(cdb_rob_name), 32'd11);
    tick();
    chk("t5_next_rob", 32'(cdb_rob_name), 32'd12);
    tick();
    chk("t5_drained", 32'(cdb_sgn), 32'd0);

    // 6: reset mid-stream with four entries buffered
    do_reset();
    set_req(0, 1'b1, 32'h61, 4'd1);
    set_req(1, 1'b1, 32'h62, 4'd2);
    set_req(2, 1'b1, 32'h63, 4'd3);
    tick();
    req_valid = '0;
    set_req(1, 1'b1, 32'h64, 4'd4);
    set_req(2, 1'b1, 32'h65, 4'd5);
    tick();
    chk("t6_pre_ready", 32'(req_ready), 32'b001);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_sgn", 32'(cdb_sgn), 32'd0);
    chk("t6_result", cdb_result, 32'd0);
    chk("t6_rob", 32'(cdb_rob_name), 32'd0);
    chk("t6_src", 32'(cdb_src), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'b111);
    set_req(0, 1'b1, 32'h66, 4'd6);
    set_req(1, 1'b1, 32'h67, 4'd7);
    set_req(2, 1'b1, 32'h68, 4'd8);
    tick();
    idle();
    tick();
    chk("t6_first_src", 32'(cdb_src), 32'd0);
    chk("t6_first_rob", 32'(cdb_rob_name), 32'd6);
    tick();
    tick();
    tick();
    chk("t6_drained", 32'(cdb_sgn), 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares one common data bus (CDB) among NREQ result producers (ALU, load/store buffer, branch unit) feeding ROB, RS and LSB.
- Each producer pushes {result, ROB tag} into a private small FIFO.
- A round-robin arbiter pops at most one entry per cycle and drives a registered broadcast.
- Misprediction flush discards all buffered results.

Parameters:
- NREQ, 3, number of producer ports.
- DEPTH, 2, entries per producer FIFO (power of two, >= 2).
- ROBW, 4, ROB tag width (16-entry ROB).
- DW, 32, result width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- flush  in  1  jump-wrong recovery; discard all buffered and in-flight results.
- req_valid  in  NREQ  producer i has a result this cycle.
- req_result  in  NREQ*DW  result of producer i, bits [i*DW +: DW].
- req_rob  in  NREQ*ROBW  ROB tag of producer i, bits [i*ROBW +: ROBW].
- req_ready  out  NREQ  FIFO i can accept (count_i < DEPTH).
- cdb_sgn  out  1  broadcast valid.
- cdb_result  out  DW  broadcast value.
- cdb_rob_name  out  ROBW  broadcast ROB tag.
- cdb_src  out  2  index of the granted producer.

Behaviour:
- Reset (rst high at an edge; rst has priority over rdy and flush):
  - all FIFOs empty, counts 0, rr_ptr = 0.
  - cdb_sgn = 0, cdb_result = 0, cdb_rob_name = 0, cdb_src = 0.
  - req_ready = all ones after reset.
- rdy low: no push, no pop, outputs and rr_ptr hold their values. Producers must hold their request.
- req_ready[i] is driven purely from registered count_i. It is not relieved by a same-cycle pop; a full FIFO refuses the push even when it is being granted.
- Push: at an edge with rdy & req_valid[i] & req_ready[i], write {req_rob, req_result} at wptr_i, then wptr_i+1 (wraps modulo DEPTH) and count_i+1.
- Arbitration is combinational each cycle over the non-empty FIFOs. Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NREQ. The first non-empty FIFO wins.
- On a grant g, at the edge:
  - pop FIFO g head (rptr_g+1 wraps, count_g-1).
  - cdb_sgn <= 1; cdb_result and cdb_rob_name <= head fields; cdb_src <= g.
  - rr_ptr <= (g+1) mod NREQ.
- No grant: cdb_sgn <= 0. cdb_result, cdb_rob_name and cdb_src hold.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Latency:
  - a push at edge N is visible on the CDB during the cycle after edge N+1 at the earliest (empty FIFO, wins arbitration).
  - Throughput is 1 broadcast per cycle overall.
  - Starvation bound: a non-empty FIFO is granted within NREQ cycles.
- Ordering: per-producer FIFO order is preserved. No ordering is guaranteed across producers.
- Flush (rdy high):
  - at the edge all counts and pointers go to 0, rr_ptr = 0, cdb_sgn <= 0.
  - pushes presented in the flush cycle are dropped.
  - a grant computed in the flush cycle is not broadcast.
- Flush with rdy low is ignored. The ROB holds jp_wrong until rdy returns.
- Tags are passed through unchecked. Duplicate tags are broadcast in FIFO order.
- cdb_src is encoded 2 bits wide, so NREQ <= 4.

Test Plan:
- Reset, then single ALU push {res=0x0000_00AA, rob=5} at edge 1 -> cdb_sgn=1, cdb_rob_name=5, cdb_result=0xAA, cdb_src=0 after edge 2; cdb_sgn=0 after edge 3.
- All three producers push every cycle for 6 cycles (rob 1..6 from each) -> cdb_src sequence 0,1,2,0,1,2...; each source's tags come out in order; req_ready drops to 0 when count=2 and no overflow occurs.
- Fill FIFO 1 to DEPTH=2 while producers 0 and 2 are idle -> req_ready[1]=0. The same-cycle pop does not re-enable the push. req_ready[1]=1 on the next cycle after the pop.
- Two entries buffered plus flush with a simultaneous push from producer 2 -> after the edge all counts 0, cdb_sgn=0, no broadcast of any of the three results, rr_ptr=0.
- rdy low for 3 cycles while cdb_sgn=1 with tag 7 -> outputs frozen at tag 7, no pops. After rdy rises, arbitration resumes from the held rr_ptr.
- rst asserted mid-stream with 4 entries buffered -> next cycle all outputs 0, req_ready=3'b111, and the first post-reset grant goes to source 0.
